// File: rtl/gppcu_dec_pkg.sv
// gppcu_dec_pkg: shared types and constants for the one-hot dispatch decoder.
//   dec_state_t : output-stage state (IDLE: nothing issued, ISSUE: strobe live)
//   DONE_CNT_W  : width of the completed-transaction counter
//   decbw()     : number of target lanes for a given index width
package gppcu_dec_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } dec_state_t;

    localparam int DONE_CNT_W = 16;

    function automatic int decbw(input int ebw);
        return 1 << ebw;
    endfunction

endpackage

// File: rtl/onehot_decode.sv
// onehot_decode: combinational lane index -> one-hot strobe.
// Optional feature macro: DEC_BCAST_EN (adds bcast input; bcast forces all ones).
// Ports:
//   index  in  EBW    lane index
//   bcast  in  1      broadcast override (DEC_BCAST_EN only)
//   strobe out DECBW  one-hot (or all-ones) lane strobe
module onehot_decode
    import gppcu_dec_pkg::*;
#(
    parameter  int EBW   = 4,
    localparam int DECBW = decbw(EBW)
) (
    input  logic [EBW-1:0]   index,
`ifdef DEC_BCAST_EN
    input  logic             bcast,
`endif
    output logic [DECBW-1:0] strobe
);

    always_comb begin
        strobe        = '0;
        strobe[index] = 1'b1;
`ifdef DEC_BCAST_EN
        if (bcast) begin
            strobe = '1;
        end
`endif
    end

endmodule

// File: rtl/onehot_dispatch_decoder.sv
// onehot_dispatch_decoder: accepts a lane index over valid/ready and drives a
// registered one-hot strobe to DECBW lanes, held until every strobed lane has
// acknowledged (acks may arrive over several cycles). A two-entry buffer
// (output stage + skid register) keeps full throughput while IN_READY comes
// straight from a flop.
// Optional feature macro: DEC_BCAST_EN (IN_BCAST port, all-lane broadcast).
//
// Handshake: a request transfers on a rising CLK edge where IN_VALID and
// IN_READY are both 1. IN_READY depends only on internal state (skid empty);
// the requester must hold IN_INDEX stable while IN_VALID=1 and IN_READY=0.
//
// Ports:
//   CLK, RSTn   clock, asynchronous active-low reset
//   IN_VALID    in   request valid
//   IN_READY    out  request may be accepted this cycle
//   IN_INDEX    in   target lane index
//   IN_BCAST    in   broadcast request (DEC_BCAST_EN only)
//   OUT_VALID   out  output stage holds a live transaction
//   OUT_STROBE  out  one-hot lane strobe (all ones on broadcast)
//   OUT_INDEX   out  index of live transaction (0 on broadcast)
//   OUT_ACK     in   per-lane acknowledge
//   DONE_COUNT  out  completed-transaction counter (wraps)
//   dbg_state   out  output-stage state for observation
module onehot_dispatch_decoder
    import gppcu_dec_pkg::*;
#(
    parameter  int EBW   = 4,
    localparam int DECBW = decbw(EBW)
) (
    input  logic                  CLK,
    input  logic                  RSTn,
    input  logic                  IN_VALID,
    output logic                  IN_READY,
    input  logic [EBW-1:0]        IN_INDEX,
`ifdef DEC_BCAST_EN
    input  logic                  IN_BCAST,
`endif
    output logic                  OUT_VALID,
    output logic [DECBW-1:0]      OUT_STROBE,
    output logic [EBW-1:0]        OUT_INDEX,
    input  logic [DECBW-1:0]      OUT_ACK,
    output logic [DONE_CNT_W-1:0] DONE_COUNT,
    output dec_state_t            dbg_state
);

    dec_state_t              state;
    logic [DECBW-1:0]        strobe_q;
    logic [EBW-1:0]          index_q;
    logic [DECBW-1:0]        ack_seen;
    logic                    skid_full;
    logic [EBW-1:0]          skid_index;
    logic [DONE_CNT_W-1:0]   done_q;
`ifdef DEC_BCAST_EN
    logic                    skid_bcast;
`endif

    logic                    accept;
    logic [DECBW-1:0]        acked_all;
    logic                    complete;
    logic [EBW-1:0]          load_index;
    logic                    load_bcast;
    logic [DECBW-1:0]        load_strobe;
    logic [EBW-1:0]          load_out_index;

    assign accept    = IN_VALID & ~skid_full;
    // Acks on lanes outside the live strobe are masked off here.
    assign acked_all = ack_seen | (OUT_ACK & strobe_q);
    assign complete  = (state == ISSUE) && (acked_all == strobe_q);

    // The skid always has priority for the next output-stage load; while it
    // is full IN_READY is low, so no input can compete with it.
    assign load_index = skid_full ? skid_index : IN_INDEX;
`ifdef DEC_BCAST_EN
    assign load_bcast = skid_full ? skid_bcast : IN_BCAST;
`else
    assign load_bcast = 1'b0;
`endif
    assign load_out_index = load_bcast ? '0 : load_index;

    onehot_decode #(.EBW(EBW)) u_decode (
        .index  (load_index),
`ifdef DEC_BCAST_EN
        .bcast  (load_bcast),
`endif
        .strobe (load_strobe)
    );

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state      <= IDLE;
            strobe_q   <= '0;
            index_q    <= '0;
            ack_seen   <= '0;
            skid_full  <= 1'b0;
            skid_index <= '0;
            done_q     <= '0;
`ifdef DEC_BCAST_EN
            skid_bcast <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state    <= ISSUE;
                        strobe_q <= load_strobe;
                        index_q  <= load_out_index;
                        ack_seen <= '0;
                    end
                end
                ISSUE: begin
                    if (complete) begin
                        done_q   <= done_q + 1'b1;
                        ack_seen <= '0;
                        if (skid_full) begin
                            strobe_q  <= load_strobe;
                            index_q   <= load_out_index;
                            skid_full <= 1'b0;
                        end else if (accept) begin
                            strobe_q <= load_strobe;
                            index_q  <= load_out_index;
                        end else begin
                            state    <= IDLE;
                            strobe_q <= '0;
                        end
                    end else begin
                        ack_seen <= acked_all;
                        if (accept) begin
                            skid_index <= IN_INDEX;
                            skid_full  <= 1'b1;
`ifdef DEC_BCAST_EN
                            skid_bcast <= IN_BCAST;
`endif
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign IN_READY   = ~skid_full;
    assign OUT_VALID  = (state == ISSUE);
    assign OUT_STROBE = strobe_q;
    assign OUT_INDEX  = index_q;
    assign DONE_COUNT = done_q;
    assign dbg_state  = state;

endmodule
